// File: rtl/line_readout_sequencer.sv
// Frame-level sequencer for the line-sensor ADC path: arms on enable, times one ADC
// conversion per pixel trigger, captures and tags samples, and closes each frame.
module line_readout_sequencer #(
  parameter int unsigned PIXELS_PER_FRAME = 1024,
  parameter int unsigned CONV_DELAY       = 4,
  parameter int unsigned CONV_PULSE       = 8,
  parameter int unsigned TRIG_TIMEOUT     = 65535,
  parameter int unsigned ADC_W            = 12
) (
  input  logic             clk_200MHz_i,
  input  logic             reset_n,
  input  logic             signal_to_diods_output,
  input  logic             AD_sp_signal,
  input  logic             AD_trig_signal,
  input  logic [ADC_W-1:0] adc_data_i,
  input  logic             clear_err_i,
  output logic             clock_to_ADC_o,
  output logic [ADC_W-1:0] pixel_data_o,
  output logic [15:0]      pixel_index_o,
  output logic             pixel_valid_o,
  output logic             reset_after_end_frame,
  output logic             frame_active_o,
  output logic [15:0]      frame_count_o,
  output logic             trig_overrun_o,
  output logic             timeout_err_o
);

  localparam logic [15:0] LastPix     = 16'(PIXELS_PER_FRAME - 1);
  localparam logic [31:0] DelayLast   = 32'(CONV_DELAY - 1);
  localparam logic [31:0] PulseLast   = 32'(CONV_PULSE - 1);
  localparam logic [31:0] TimeoutLast = 32'(TRIG_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StArmed, StWaitTrig, StDelay, StPulse, StCapture, StEnd
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      tmr_q, tmr_d;
  logic [15:0]      pix_q, pix_d;
  logic [15:0]      idx_q, idx_d;
  logic [ADC_W-1:0] data_q, data_d;
  logic [15:0]      fcnt_q, fcnt_d;
  logic             end_ok_q, end_ok_d;
  logic             ovr_q, ovr_d;
  logic             to_q, to_d;
  logic             trig_q;
  logic             trig_edge;
  logic             busy;
  logic             to_set;

  assign trig_edge = AD_trig_signal & ~trig_q;
  assign busy      = (state_q == StDelay) || (state_q == StPulse) || (state_q == StCapture);

  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    idx_d    = idx_q;
    data_d   = data_q;
    fcnt_d   = fcnt_q;
    end_ok_d = end_ok_q;
    to_set   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (signal_to_diods_output) state_d = StArmed;
      end
      StArmed: begin
        if (AD_sp_signal) begin
          state_d = StWaitTrig;
          pix_d   = '0;
        end
      end
      StWaitTrig: begin
        if (trig_edge) begin
          state_d = StDelay;
        end else if (tmr_q == TimeoutLast) begin
          state_d  = StEnd;
          to_set   = 1'b1;
          end_ok_d = 1'b0;
        end
      end
      StDelay: begin
        if (tmr_q == DelayLast) state_d = StPulse;
      end
      StPulse: begin
        if (tmr_q == PulseLast) state_d = StCapture;
      end
      StCapture: begin
        if (pix_q == LastPix) begin
          state_d  = StEnd;
          end_ok_d = 1'b1;
        end else begin
          state_d = StWaitTrig;
          pix_d   = pix_q + 16'd1;
        end
      end
      StEnd: begin
        if (end_ok_q) fcnt_d = fcnt_q + 16'd1;
        state_d = signal_to_diods_output ? StArmed : StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Losing enable mid-frame drops straight to idle with no end pulse or capture.
    if (!signal_to_diods_output && state_q != StIdle && state_q != StEnd) begin
      state_d = StIdle;
      pix_d   = pix_q;
      to_set  = 1'b0;
    end

    if (state_q == StPulse && state_d == StCapture) begin
      data_d = adc_data_i;
      idx_d  = pix_q;
    end

    if (state_d != state_q || state_d == StIdle || state_d == StArmed) tmr_d = '0;
    else                                                                 tmr_d = tmr_q + 32'd1;

    // Set wins over a simultaneous clear.
    ovr_d = clear_err_i ? 1'b0 : ovr_q;
    if (trig_edge && busy) ovr_d = 1'b1;
    to_d = clear_err_i ? 1'b0 : to_q;
    if (to_set) to_d = 1'b1;
  end

  always_ff @(posedge clk_200MHz_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      tmr_q    <= '0;
      pix_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      fcnt_q   <= '0;
      end_ok_q <= 1'b0;
      ovr_q    <= 1'b0;
      to_q     <= 1'b0;
      trig_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      pix_q    <= pix_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      fcnt_q   <= fcnt_d;
      end_ok_q <= end_ok_d;
      ovr_q    <= ovr_d;
      to_q     <= to_d;
      trig_q   <= AD_trig_signal;
    end
  end

  assign clock_to_ADC_o        = (state_q == StPulse);
  assign pixel_valid_o         = (state_q == StCapture);
  assign reset_after_end_frame = (state_q == StEnd);
  assign frame_active_o        = (state_q == StWaitTrig) || busy;
  assign pixel_data_o          = data_q;
  assign pixel_index_o         = idx_q;
  assign frame_count_o         = fcnt_q;
  assign trig_overrun_o        = ovr_q;
  assign timeout_err_o         = to_q;

endmodule

// File: doc/line_readout_sequencer.md
# line_readout_sequencer

Frame-level controller for the line-sensor ADC path. It arms on the diode output enable and starts a frame on the frame-start strobe. For each pixel trigger it generates a timed ADC conversion clock pulse, then captures the converted sample and tags it with its pixel index. After the programmed pixel count it closes the frame with a one-cycle end-of-frame pulse, which also re-arms the upstream start/trigger qualification. It sits between the sensor timing inputs and the pixel buffer.

## Interface
Parameters:
- PIXELS_PER_FRAME, 1024: pixels per frame, 2..65535
- CONV_DELAY, 4: clocks from trigger edge to ADC clock rise, ≥1
- CONV_PULSE, 8: ADC clock high width in clocks, ≥1
- TRIG_TIMEOUT, 65535: max clocks waiting for a trigger inside a frame, ≥1
- ADC_W, 12: ADC sample width

Ports:
- clk_200MHz_i  in  1  200 MHz system clock
- reset_n  in  1  asynchronous, active-low reset
- signal_to_diods_output  in  1  enable; level, synchronous
- AD_sp_signal  in  1  frame-start strobe, level, synchronous
- AD_trig_signal  in  1  pixel trigger; rising edge counts
- adc_data_i  in  ADC_W  ADC conversion result
- clear_err_i  in  1  clears sticky error flags
- clock_to_ADC_o  out  1  ADC conversion clock pulse
- pixel_data_o  out  ADC_W  captured sample
- pixel_index_o  out  16  index of captured sample, 0-based
- pixel_valid_o  out  1  one-cycle qualifier for the data and index outputs
- reset_after_end_frame  out  1  one-cycle end-of-frame / abort pulse
- frame_active_o  out  1  high from frame start to frame end
- frame_count_o  out  16  completed frames, wraps 0xFFFF→0
- trig_overrun_o  out  1  sticky: trigger edge arrived while busy
- timeout_err_o  out  1  sticky: trigger wait exceeded TRIG_TIMEOUT

## Operation
- Reset: all outputs 0, state IDLE, pixel counter 0, trigger-edge history register 0.
- Trigger edge: AD_trig_signal is 1 this cycle and its registered value was 0 on the previous cycle.
- States:
  - IDLE → ARMED when signal_to_diods_output=1.
  - ARMED → WAIT_TRIG when AD_sp_signal=1. Pixel counter is cleared and frame_active_o is set.
  - WAIT_TRIG → DELAY on a trigger edge. The timeout counter increments every cycle in this state and is cleared on entry. If it reaches TRIG_TIMEOUT: set timeout_err_o, go to END, and do not increment frame_count_o.
  - DELAY → PULSE after CONV_DELAY cycles.
  - PULSE → CAPTURE after CONV_PULSE cycles. clock_to_ADC_o=1 only in PULSE.
  - CAPTURE → END if the pixel counter equals PIXELS_PER_FRAME-1; otherwise the counter increments and the state goes to WAIT_TRIG. In CAPTURE, pixel_valid_o=1 and pixel_index_o=counter.
  - END lasts one cycle: reset_after_end_frame=1, frame_active_o cleared. frame_count_o increments on normal completion only. Next state is ARMED if enabled, else IDLE.
- Trigger edges in DELAY, PULSE or CAPTURE are ignored and set trig_overrun_o. The ignored trigger does not advance the pixel counter.
- AD_sp_signal outside ARMED is ignored.
- signal_to_diods_output dropping in any state except IDLE aborts the frame:
  - next state IDLE;
  - clock_to_ADC_o and frame_active_o go 0 next cycle;
  - no end pulse and no pixel_valid_o.
- clear_err_i=1 clears both sticky flags. A set and a clear in the same cycle leave the flag set.
- pixel_data_o and pixel_index_o hold their values between valid pulses.

## Timing
- Let E be the cycle of the trigger edge, D=CONV_DELAY, P=CONV_PULSE.
- clock_to_ADC_o is high in cycles E+1+D through E+D+P.
- pixel_valid_o is high in cycle E+1+D+P. pixel_data_o holds adc_data_i sampled at the rising edge that starts that cycle.
- The next trigger edge is accepted from cycle E+2+D+P.
- For the last pixel, reset_after_end_frame is high in cycle E+2+D+P. frame_count_o shows the new value from E+3+D+P.
- AD_sp_signal seen at cycle S: frame_active_o is high from S+1.
- Reset deassertion mid-frame: the block restarts in IDLE. No partial outputs are emitted.

## Test plan
- PIXELS_PER_FRAME=4, D=4, P=8. Enable, start pulse, 4 trigger edges spaced 20 cycles apart → 4 ADC pulses, each 8 cycles high starting 5 cycles after its edge. Indices 0..3 captured with data matching adc_data_i. End pulse 14 cycles after the 4th edge. frame_count_o=1.
- Trigger edge 3 cycles after a previous edge → trig_overrun_o=1 and no extra pulse. Frame completes after 4 accepted edges. clear_err_i clears the flag.
- No trigger after start, TRIG_TIMEOUT=100 → timeout_err_o=1 and end pulse about 100 cycles after entering WAIT_TRIG. frame_count_o unchanged.
- Enable dropped during PULSE → clock_to_ADC_o low next cycle, no valid, no end pulse, state IDLE.
- Triggers before the start pulse and a start pulse while a frame is active → both ignored, no ADC pulses.
- 65536 short frames (PIXELS_PER_FRAME=2) → frame_count_o wraps to 0.
